// File: rtl/ring_decoder_checker.sv
// ring_decoder_checker: decodes a one-hot ring to a binary index and flags illegal steps; `define RING_RESYNC_EN lets a fault fall back to SYNC
module ring_decoder_checker #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Ring_in,
  output logic [IDX_W-1:0] Index_out,
  output logic             Valid_out,
  output logic             Error_out,
  output logic [LAP_W-1:0] Lap_count,
  output logic             Lap_tick
);
  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [IDX_W-1:0] idx;
  logic             one_hot;
  logic [WIDTH-1:0] expected;
  // OR-reduction of bit positions is exact for a one-hot input
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (Ring_in[i]) idx = idx | IDX_W'(i);
  end
  assign one_hot  = $onehot(Ring_in);
  assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= SYNC;
      prev      <= '0;
      Index_out <= '0;
      Valid_out <= 1'b0;
      Error_out <= 1'b0;
      Lap_count <= '0;
      Lap_tick  <= 1'b0;
    end else begin
      Lap_tick <= 1'b0;
      if (state == SYNC) begin
        if (one_hot) begin
          prev      <= Ring_in;
          Index_out <= idx;
          Valid_out <= 1'b1;
          state     <= TRACK;
        end
      end else if (state == TRACK) begin
        if (Ring_in == expected) begin
          prev      <= Ring_in;
          Index_out <= idx;
          if (prev[WIDTH-1]) begin
            Lap_count <= Lap_count + LAP_W'(1);
            Lap_tick  <= 1'b1;
          end
        end else begin
          state     <= FAULT;
          Error_out <= 1'b1;
          Valid_out <= 1'b0;
        end
      end else begin
        Valid_out <= 1'b0;
`ifdef RING_RESYNC_EN
        state <= SYNC;
`else
        state <= FAULT;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ring_decoder_checker.sv
// tb_ring_decoder_checker: randomized and directed checks of ring_decoder_checker against a position-based reference model
module tb_ring_decoder_checker;
  localparam int W = 4;
  logic       Clock = 0;
  logic       Reset = 1;
  logic [3:0] Ring_in = 4'b0001;
  logic [1:0] Index_out;
  logic       Valid_out, Error_out, Lap_tick;
  logic [1:0] Lap_count;
  int n_cmp = 0, n_err = 0;
  int m_state, m_pos, m_lap;
  logic [1:0] m_idx;
  logic m_valid, m_err, m_tick;

  ring_decoder_checker #(.WIDTH(4), .LAP_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .Ring_in(Ring_in), .Index_out(Index_out),
    .Valid_out(Valid_out), .Error_out(Error_out), .Lap_count(Lap_count), .Lap_tick(Lap_tick)
  );

  always #5 Clock = ~Clock;

  function automatic logic [6:0] got();
    return {Index_out, Valid_out, Error_out, Lap_count, Lap_tick};
  endfunction

  function automatic logic [6:0] want();
    return {m_idx, m_valid, m_err, 2'(m_lap), m_tick};
  endfunction

  function automatic logic [3:0] pos_bit(input int p);
    return 4'(1 << (p % W));
  endfunction

  // model: state 0=sync 1=track 2=fault; position tracked as an integer
  task automatic step(input logic [3:0] r, input logic rst);
    @(negedge Clock);
    Ring_in = r;
    Reset = rst;
    @(posedge Clock);
    m_tick = 0;
    if (rst) begin
      m_state = 0; m_pos = 0; m_idx = 0; m_valid = 0; m_err = 0; m_lap = 0;
    end else if (m_state == 0) begin
      if ($countones(r) == 1) begin
        m_pos = $clog2(r); m_idx = 2'(m_pos); m_valid = 1; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (r == pos_bit(m_pos + 1)) begin
        if (m_pos == W - 1) begin m_tick = 1; m_lap = (m_lap + 1) % 4; end
        m_pos = (m_pos + 1) % W; m_idx = 2'(m_pos);
      end else begin
        m_state = 2; m_err = 1; m_valid = 0;
      end
    end else begin
      m_valid = 0;
`ifdef RING_RESYNC_EN
      m_state = 0;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 1);
      n_cmp++;
      if (got() !== 7'b0) begin
        n_err++; $display("FAIL reset cyc%0d got=%b want=%b", i, got(), 7'b0);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [6:0] exp_v;
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 0);
      exp_v = {idx[i], 1'b1, 1'b0, (i == 4) ? 2'd1 : 2'd0, i == 4};
      n_cmp++;
      if (got() !== exp_v || got() !== want()) begin
        n_err++; $display("FAIL rotation step%0d got=%b want=%b model=%b", i, got(), exp_v, want());
      end
    end
  endtask

  task automatic test_sync_zero();
    step(4'b0001, 1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 0);
      n_cmp++;
      if (Valid_out !== 1'b0 || Error_out !== 1'b0 || got() !== want()) begin
        n_err++; $display("FAIL sync_zero cyc%0d got=%b want=%b", i, got(), want());
      end
    end
    step(4'b0100, 0);
    n_cmp++;
    if (Index_out !== 2'd2 || Valid_out !== 1'b1 || got() !== want()) begin
      n_err++; $display("FAIL sync_capture got=%b want idx=2 valid=1", got());
    end
  endtask

  task automatic test_faults();
    logic [3:0] bad [3] = '{4'b1000, 4'b0010, 4'b0011};
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1);
      step(4'b0001, 0);
      step(4'b0010, 0);
      step(bad[k], 0);
      n_cmp++;
      if (Error_out !== 1'b1 || Valid_out !== 1'b0 || Index_out !== 2'd1 || got() !== want()) begin
        n_err++; $display("FAIL fault bad=%b got=%b want idx=1 valid=0 err=1", bad[k], got());
      end
      for (int i = 0; i < 4; i++) begin
        step(pos_bit(i), 0);
        n_cmp++;
        if (got() !== want()) begin
          n_err++; $display("FAIL fault_after bad=%b cyc%0d got=%b want=%b", bad[k], i, got(), want());
        end
      end
    end
  endtask

  task automatic test_laps();
    int ticks = 0;
    step(4'b0001, 1);
    step(4'b0001, 0);
    for (int i = 1; i <= 16; i++) begin
      step(pos_bit(i), 0);
      ticks += int'(Lap_tick);
      n_cmp++;
      if (got() !== want() || Lap_count !== 2'(i / 4)) begin
        n_err++; $display("FAIL laps step%0d got=%b want=%b", i, got(), want());
      end
    end
    n_cmp++;
    if (ticks != 4 || Lap_count !== 2'd0) begin
      n_err++; $display("FAIL lap_total ticks=%0d count=%0d want ticks=4 count=0", ticks, Lap_count);
    end
  endtask

  task automatic test_fault_reset();
    step(4'b0001, 1);
    step(4'b0001, 0);
    step(4'b0001, 0);
    step(4'b0001, 1);
    n_cmp++;
    if (got() !== 7'b0) begin
      n_err++; $display("FAIL fault_reset got=%b want=%b", got(), 7'b0);
    end
    step(4'b0001, 0);
    step(4'b0100, 0);
    step(4'b0001, 0);
    step(4'b0001, 0);
    n_cmp++;
`ifdef RING_RESYNC_EN
    if (Valid_out !== 1'b1 || Error_out !== 1'b1 || Index_out !== 2'd0 || got() !== want()) begin
      n_err++; $display("FAIL resync got=%b want valid=1 err=1 idx=0", got());
    end
`else
    if (Valid_out !== 1'b0 || Error_out !== 1'b1 || Index_out !== 2'd0 || got() !== want()) begin
      n_err++; $display("FAIL terminal_fault got=%b want valid=0 err=1 idx=0", got());
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic rst;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(99);
      rst = (sel < 2);
      r = (sel < 12) ? 4'($urandom) : (m_state == 1) ? pos_bit(m_pos + 1) : pos_bit($urandom_range(3));
      step(r, rst);
      n_cmp++;
      if (got() !== want()) begin
        n_err++; $display("FAIL random cyc%0d r=%b rst=%b got=%b want=%b", i, r, rst, got(), want());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_sync_zero();
    test_faults();
    test_laps();
    test_fault_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
